// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory port. One transaction
// at a time: pick an owner in IDLE, run a 1-cycle write or an issue/wait/done
// read sequence, pulse the owner's grant, then rotate priority past it.

// Per-processor grant decode: a lane raises its grant only while it owns the
// port and the sequencer is in the matching completion state.
module mem_arbiter_lane #(
  parameter int            PW  = 2,
  parameter logic [PW-1:0] IDX = '0
) (
  input  logic [PW-1:0] owner,
  input  logic          wr_done,
  input  logic          rd_done,
  output logic          grant_wr,
  output logic          grant_rd
);
  assign grant_wr = wr_done && (owner == IDX);
  assign grant_rd = rd_done && (owner == IDX);
endmodule

module mem_arbiter #(
  parameter int PROC_COUNT = 4,
  parameter int BUS_SIZE   = 128,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [PROC_COUNT-1:0]                i_req_rd,
  input  logic [PROC_COUNT-1:0]                i_req_wr,
  input  logic [PROC_COUNT-1:0][ADDR_W-1:0]    i_proc_addr,
  input  logic [PROC_COUNT-1:0][BUS_SIZE-1:0]  i_proc_wr,
  input  logic [PROC_COUNT-1:0][2:0]           i_wr_size,
  output logic [PROC_COUNT-1:0]                o_grant_rd,
  output logic [PROC_COUNT-1:0]                o_grant_wr,
  output logic [BUS_SIZE-1:0]                  o_proc_rd,
  output logic                                 o_busy,
  output logic                                 o_mem_en,
  output logic                                 o_mem_we,
  output logic [ADDR_W-1:0]                    o_mem_addr,
  output logic [BUS_SIZE-1:0]                  o_mem_wdata,
  output logic [2:0]                           o_mem_wsize,
  input  logic [BUS_SIZE-1:0]                  i_mem_rdata
);
  localparam int PW = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE} state_t;

  state_t                  state, state_n;
  logic [PW-1:0]           rr_ptr, owner, owner_inc;
  logic [CW-1:0]           cnt;
  logic [PROC_COUNT-1:0]   req;
  logic                    sel_found;
  logic [PW-1:0]           sel_idx;
  logic [PW:0]             rr_sum;
  logic [PW-1:0]           rr_cand;
  logic                    wr_done, rd_done;

  assign req       = i_req_rd | i_req_wr;
  assign owner_inc = (owner == PW'(PROC_COUNT - 1)) ? '0 : owner + 1'b1;
  assign o_busy    = (state != IDLE);

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo
  // PROC_COUNT (the sum never exceeds 2*PROC_COUNT-2, so one subtract wraps).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int i = 0; i < PROC_COUNT; i++) begin
      rr_sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (rr_sum >= (PW+1)'(PROC_COUNT)) rr_sum = rr_sum - (PW+1)'(PROC_COUNT);
      rr_cand = rr_sum[PW-1:0];
      if (!sel_found && req[rr_cand]) begin
        sel_found = 1'b1;
        sel_idx   = rr_cand;
      end
    end
  end

  // State register plus the owner/operand latches, read counter and read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      owner       <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wsize <= '0;
      o_proc_rd   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (sel_found) begin
          owner       <= sel_idx;
          o_mem_addr  <= i_proc_addr[sel_idx];
          o_mem_wdata <= i_proc_wr[sel_idx];
          o_mem_wsize <= i_wr_size[sel_idx];
        end
        WR:       rr_ptr <= owner_inc;
        RD_ISSUE: cnt <= CW'(1);
        RD_WAIT: begin
          if (cnt == CW'(RD_LAT)) o_proc_rd <= i_mem_rdata;
          else                    cnt <= cnt + 1'b1;
        end
        RD_DONE:  rr_ptr <= owner_inc;
        default: ;
      endcase
    end
  end

  // Next-state and memory strobes; a write wins when a proc asks for both.
  always_comb begin
    state_n  = state;
    o_mem_en = 1'b0;
    o_mem_we = 1'b0;
    wr_done  = 1'b0;
    rd_done  = 1'b0;
    case (state)
      IDLE: if (sel_found) state_n = i_req_wr[sel_idx] ? WR : RD_ISSUE;
      WR: begin
        o_mem_en = 1'b1;
        o_mem_we = 1'b1;
        wr_done  = 1'b1;
        state_n  = IDLE;
      end
      RD_ISSUE: begin
        o_mem_en = 1'b1;
        state_n  = RD_WAIT;
      end
      RD_WAIT: if (cnt == CW'(RD_LAT)) state_n = RD_DONE;
      RD_DONE: begin
        rd_done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar g = 0; g < PROC_COUNT; g++) begin : g_lane
    mem_arbiter_lane #(.PW(PW), .IDX(PW'(g))) u_lane (
      .owner    (owner),
      .wr_done  (wr_done),
      .rd_done  (rd_done),
      .grant_wr (o_grant_wr[g]),
      .grant_rd (o_grant_rd[g])
    );
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random request
// traffic, all checked every cycle against a transaction-timeline model.
module tb_mem_arbiter;
  localparam int P  = 4;
  localparam int PW = 2;
  localparam int BW = 128;
  localparam int AW = 16;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [P-1:0]           req_rd, req_wr;
  logic [P-1:0][AW-1:0]   paddr;
  logic [P-1:0][BW-1:0]   pwd;
  logic [P-1:0][2:0]      pws;
  logic [P-1:0]           grant_rd, grant_wr;
  logic [BW-1:0]          proc_rd, mem_wdata, mem_rdata;
  logic                   busy, mem_en, mem_we;
  logic [AW-1:0]          mem_addr;
  logic [2:0]             mem_wsize;

  mem_arbiter #(.PROC_COUNT(P), .BUS_SIZE(BW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_rd(req_rd), .i_req_wr(req_wr),
    .i_proc_addr(paddr), .i_proc_wr(pwd), .i_wr_size(pws),
    .o_grant_rd(grant_rd), .o_grant_wr(grant_wr), .o_proc_rd(proc_rd),
    .o_busy(busy), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wsize(mem_wsize), .i_mem_rdata(mem_rdata)
  );

  // Contents of a location never written since reset.
  function automatic logic [BW-1:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? {4{32'hDEAD_BEEF}} : ({16{a}} ^ {4{32'h0123_4567}});
  endfunction

  // Memory environment: 256 words (low address byte), read data appears
  // exactly RL cycles after the read strobe, junk in every other cycle.
  logic [BW-1:0] env_mem [256];
  logic [255:0]  env_valid;
  logic [BW-1:0] dl [RL];
  assign mem_rdata = dl[RL-1];

  always @(posedge clk) begin
    if (rst) env_valid <= '0;
    else if (mem_en && mem_we) begin
      env_mem[mem_addr[7:0]]   <= mem_wdata;
      env_valid[mem_addr[7:0]] <= 1'b1;
    end
    dl[0] <= (mem_en && !mem_we)
             ? (env_valid[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]))
             : {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k < RL; k++) dl[k] <= dl[k-1];
  end

  // Reference model: a transaction occupies m_len cycles (1 for a write,
  // 2+RL for a read); m_t is the position inside it, 0 when the port is idle.
  int            errors = 0, checks = 0;
  int            m_t, m_len, m_owner, m_rr;
  bit            m_isw;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wd, m_prd;
  logic [2:0]    m_ws;
  logic [BW-1:0] ref_mem [256];
  bit   [255:0]  ref_valid;

  function automatic logic [BW-1:0] ref_rd(input logic [7:0] a);
    return ref_valid[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    int p;
    if (rst) begin
      m_t = 0; m_len = 1; m_owner = 0; m_rr = 0; m_isw = 0;
      m_addr = '0; m_wd = '0; m_ws = '0; m_prd = '0; ref_valid = '0;
      return;
    end
    if (m_t != 0) begin
      if (m_t == m_len) begin
        if (m_isw) begin
          ref_mem[m_addr[7:0]]   = m_wd;
          ref_valid[m_addr[7:0]] = 1'b1;
        end
        m_rr = (m_owner + 1) % P;
        m_t  = 0;
      end else begin
        m_t++;
        if (m_t == m_len && !m_isw) m_prd = ref_rd(m_addr[7:0]);
      end
    end else begin
      found = 0;
      for (int i = 0; i < P; i++) begin
        p = (m_rr + i) % P;
        if (!found && (req_rd[p[PW-1:0]] || req_wr[p[PW-1:0]])) begin
          found   = 1;
          m_owner = p;
          m_isw   = req_wr[p[PW-1:0]];
          m_len   = m_isw ? 1 : 2 + RL;
          m_addr  = paddr[p[PW-1:0]];
          m_wd    = pwd[p[PW-1:0]];
          m_ws    = pws[p[PW-1:0]];
          m_t     = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [P-1:0] eg;
    eg = (m_t != 0 && m_t == m_len) ? (P'(1) << m_owner) : '0;
    chk("busy",     busy,      m_t != 0);
    chk("mem_en",   mem_en,    m_t == 1);
    chk("mem_we",   mem_we,    m_t == 1 && m_isw);
    chk("grant_wr", grant_wr,  m_isw ? eg : '0);
    chk("grant_rd", grant_rd,  m_isw ? '0 : eg);
    chk("mem_addr", mem_addr,  m_addr);
    chk("mem_wdat", mem_wdata, m_wd);
    chk("mem_wsz",  mem_wsize, m_ws);
    chk("proc_rd",  proc_rd,   m_prd);
  endtask

  // Inputs set now are sampled at the coming edge; check the next cycle.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Random requesters: drop the granted request, occasionally raise new ones
  // (rd, wr or both) with fresh operands for procs that have nothing pending.
  task automatic auto_req();
    if (m_t != 0 && m_t == m_len) begin
      if (m_isw) req_wr[m_owner[PW-1:0]] = 1'b0;
      else       req_rd[m_owner[PW-1:0]] = 1'b0;
    end
    for (int p = 0; p < P; p++) begin
      if (!req_rd[p[PW-1:0]] && !req_wr[p[PW-1:0]] && $urandom_range(3) == 0) begin
        int k;
        k = $urandom_range(2);
        paddr[p[PW-1:0]]  = {8'($urandom), 8'($urandom_range(15))};
        pwd[p[PW-1:0]]    = {$urandom, $urandom, $urandom, $urandom};
        pws[p[PW-1:0]]    = 3'($urandom);
        req_rd[p[PW-1:0]] = (k != 1);
        req_wr[p[PW-1:0]] = (k != 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_rd = '0; req_wr = '0; paddr = '0; pwd = '0; pws = '0;
    cyc(); cyc();
    chk("rst_grant", {grant_rd, grant_wr}, '0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc();

    // Single write from proc 2.
    paddr[2] = 16'h0040; pwd[2] = {16{8'hA5}}; pws[2] = 3'd3; req_wr[2] = 1'b1;
    cyc();
    chk("w1_grant", grant_wr, 4'b0100);
    chk("w1_en", {mem_en, mem_we}, 2'b11);
    chk("w1_addr", mem_addr, 16'h0040);
    chk("w1_wsize", mem_wsize, 3'd3);
    req_wr[2] = 1'b0;
    cyc();
    chk("w1_pulse", grant_wr, 4'b0000);

    // Single read from proc 1, grant 4 cycles after the sampling edge.
    paddr[1] = 16'h0010; req_rd[1] = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("r1_grant", grant_rd, 4'b0010);
    chk("r1_data", proc_rd, {4{32'hDEAD_BEEF}});
    req_rd[1] = 1'b0;
    cyc(); cyc();
    chk("r1_hold", proc_rd, {4{32'hDEAD_BEEF}});

    // All four write at once after reset: served 0,1,2,3 every other cycle.
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int p = 0; p < P; p++) begin
      paddr[p[PW-1:0]] = AW'(16'h0100 + p * 4);
      pwd[p[PW-1:0]]   = {$urandom, $urandom, $urandom, $urandom};
      pws[p[PW-1:0]]   = 3'(p);
    end
    req_wr = 4'b1111;
    for (int p = 0; p < P; p++) begin
      cyc();
      chk("rr_grant", grant_wr, P'(1) << p);
      req_wr[p[PW-1:0]] = 1'b0;
      cyc();
      chk("rr_gap", busy, 1'b0);
    end
    req_wr[0] = 1'b1;
    cyc();
    chk("rr_wrap", grant_wr, 4'b0001);
    req_wr[0] = 1'b0;
    cyc();

    // Proc 3 asks for both: write first, then the held read on the next pass.
    paddr[3] = 16'h0080; pwd[3] = {4{32'h5555_AAAA}}; pws[3] = 3'd7;
    req_rd[3] = 1'b1; req_wr[3] = 1'b1;
    cyc();
    chk("both_wr", grant_wr, 4'b1000);
    req_wr[3] = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("both_rd", grant_rd, 4'b1000);
    chk("both_data", proc_rd, {4{32'h5555_AAAA}});
    req_rd[3] = 1'b0;
    cyc();

    // Move rr_ptr to 2, then reset in the middle of a read by proc 2.
    req_wr[1] = 1'b1;
    cyc();
    req_wr[1] = 1'b0;
    cyc();
    paddr[2] = 16'h0033; req_rd[2] = 1'b1;
    cyc(); cyc();
    rst = 1'b1; req_rd[2] = 1'b0;
    cyc();
    chk("rstw_grant", {grant_rd, grant_wr}, '0);
    chk("rstw_en", {busy, mem_en, mem_we}, 3'b000);
    chk("rstw_addr", mem_addr, '0);
    chk("rstw_prd", proc_rd, '0);
    rst = 1'b0;
    cyc();
    chk("rstw_nogr", grant_rd, 4'b0000);
    req_wr[1] = 1'b1; req_wr[3] = 1'b1;
    cyc();
    chk("rstw_rr0", grant_wr, 4'b0010);
    req_wr[1] = 1'b0;
    cyc(); cyc();
    chk("rstw_next", grant_wr, 4'b1000);
    req_wr[3] = 1'b0;
    cyc();

    // Read whose request drops while waiting on memory.
    paddr[0] = 16'h0022; req_rd[0] = 1'b1;
    cyc(); cyc();
    req_rd[0] = 1'b0;
    cyc(); cyc();
    chk("drop_grant", grant_rd, 4'b0001);
    chk("drop_data", proc_rd, init_val(8'h22));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("drop_idle", busy, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      auto_req();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
